// File: rtl/led_driver_pkg.sv
// -----------------------------------------------------------------------------
// led_driver_pkg
// Shared types and constants for the LED driver core.
//   led_mode_t      : 2-bit display mode (OFF / HEAT / COOL / ALARM)
//   PAT_*           : pattern loaded into the LED bank when a mode is entered
//   init_pattern()  : maps a mode to its initial pattern
// -----------------------------------------------------------------------------
package led_driver_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_HEAT  = 2'b01,
        MODE_COOL  = 2'b10,
        MODE_ALARM = 2'b11
    } led_mode_t;

    localparam logic [15:0] PAT_OFF   = 16'h0000;
    localparam logic [15:0] PAT_HEAT  = 16'h0001;
    localparam logic [15:0] PAT_COOL  = 16'h8000;
    localparam logic [15:0] PAT_ALARM = 16'hFFFF;

    function automatic logic [15:0] init_pattern(input led_mode_t mode);
        logic [15:0] pat;
        case (mode)
            MODE_HEAT:  pat = PAT_HEAT;
            MODE_COOL:  pat = PAT_COOL;
            MODE_ALARM: pat = PAT_ALARM;
            default:    pat = PAT_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_driver_core_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Animation prescaler. Counts 0..TICK_DIV-1 and flags the last count; the
// owner applies one animation step on every edge where tick is high.
// Ports:
//   clk   in  : system clock, rising edge
//   rst   in  : asynchronous active-low reset
//   clear in  : restart the interval (mode reload); takes priority
//   tick  out : high while the counter sits on its terminal value
// Parameters:
//   TICK_DIV  : clock cycles per animation step (1..65535)
// -----------------------------------------------------------------------------
module led_tick_gen #(
    parameter int TICK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    // A divider of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (clear || (tick_cnt == CNT_LAST)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == CNT_LAST);

endmodule

// File: rtl/led_driver_core.sv
// -----------------------------------------------------------------------------
// led_driver_core
// 16-LED animation driver. A mode select picks a pattern that is loaded one
// edge after the mode changes and then animated once every TICK_DIV cycles:
// HEAT rotates left, COOL rotates right, ALARM blinks, OFF stays dark.
// Ports:
//   clk     in  [0]    : system clock, rising edge
//   rst     in  [0]    : asynchronous active-low reset
//   LED     in  [1:0]  : mode select 00 OFF, 01 HEAT, 10 COOL, 11 ALARM
//   LED_OUT out [15:0] : LED bank drive, 1 = lit
// Parameters:
//   TICK_DIV : clock cycles per animation step (1..65535)
//   PWM_DUTY : PWM on-slots out of 16 (0..16), used with LED_DRIVER_PWM_EN
// Build option:
//   LED_DRIVER_PWM_EN : when defined, gates LED_OUT with a 16-slot PWM
// -----------------------------------------------------------------------------
module led_driver_core
    import led_driver_pkg::*;
#(
    parameter int TICK_DIV = 8,
    parameter int PWM_DUTY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  LED,
    output logic [15:0] LED_OUT
);

    led_mode_t   mode_q;
    logic [15:0] pat_q;
    logic        mode_change;
    logic        tick;

    assign mode_change = (LED != mode_q);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (mode_change),
        .tick  (tick)
    );

    // A mode change wins over a coincident step: reload, do not animate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_OFF;
            pat_q  <= PAT_OFF;
        end else if (mode_change) begin
            mode_q <= led_mode_t'(LED);
            pat_q  <= init_pattern(led_mode_t'(LED));
        end else if (tick) begin
            case (mode_q)
                MODE_HEAT:  pat_q <= {pat_q[14:0], pat_q[15]};
                MODE_COOL:  pat_q <= {pat_q[0], pat_q[15:1]};
                MODE_ALARM: pat_q <= ~pat_q;
                default:    pat_q <= PAT_OFF;
            endcase
        end
    end

`ifdef LED_DRIVER_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    // Free-running; deliberately not restarted by mode changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Compare in 5 bits so a duty of 16 means always on.
    assign pwm_on  = ({1'b0, pwm_cnt} < 5'(PWM_DUTY));
    assign LED_OUT = pat_q & {16{pwm_on}};
`else
    logic [4:0] pwm_duty_unused;
    assign pwm_duty_unused = 5'(PWM_DUTY);
    assign LED_OUT = pat_q;
`endif

endmodule

// File: tb/tb_led_driver_core.sv
// -----------------------------------------------------------------------------
// tb_led_driver_core
// Self-checking bench for led_driver_core with TICK_DIV=8. A reference model
// tracks edges since the last mode load and derives the pattern from the
// number of whole steps taken; expected values are queued per edge and a
// monitor compares them against LED_OUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_led_driver_core;

    localparam int TICK_DIV = 8;
    localparam int PWM_DUTY = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  LED;
    logic [15:0] LED_OUT;

    int checks   = 0;
    int failures = 0;

    led_driver_core #(
        .TICK_DIV (TICK_DIV),
        .PWM_DUTY (PWM_DUTY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .LED     (LED),
        .LED_OUT (LED_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0] m_mode;
    int         m_since_load;
    int         m_pwm;
    logic [17:0] exp_q[$];   // {mode, expected LED_OUT}

    function automatic logic [15:0] model_pattern(input logic [1:0] mode, input int steps);
        logic [15:0] one;
        one = 16'h0001;
        case (mode)
            2'b01:   return one << (steps % 16);
            2'b10:   return 16'h8000 >> (steps % 16);
            2'b11:   return ((steps % 2) == 0) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [15:0] p;
        if (!rst) begin
            m_mode       = 2'b00;
            m_since_load = 0;
            m_pwm        = 0;
        end else begin
            if (LED != m_mode) begin
                m_mode       = LED;
                m_since_load = 0;
            end else begin
                m_since_load = m_since_load + 1;
            end
            m_pwm = (m_pwm + 1) % 16;
            p = model_pattern(m_mode, m_since_load / TICK_DIV);
`ifdef LED_DRIVER_PWM_EN
            if (!(m_pwm < PWM_DUTY)) p = 16'h0000;
`endif
            exp_q.push_back({m_mode, p});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst) begin
            exp_q.delete();
            checks++;
            if (LED_OUT !== 16'h0000) begin
                failures++;
                $display("FAIL reset_out: got %h want 0000", LED_OUT);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (LED_OUT !== e[15:0]) begin
                failures++;
                $display("FAIL pattern (mode %b): got %h want %h at %0t", e[17:16], LED_OUT, e[15:0], $time);
            end
            if ((e[17:16] == 2'b01 || e[17:16] == 2'b10) && e[15:0] != 16'h0000) begin
                checks++;
                if ($countones(LED_OUT) != 1) begin
                    failures++;
                    $display("FAIL one_hot: got %h want exactly one bit", LED_OUT);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        LED = 2'b01;
        cyc(10);
        rst = 1'b1;

        // HEAT: load, first step after 8 edges, full wrap after 128 edges
        cyc(1 + 128 + 5);

        // Switch to COOL when the prescaler is at count 5
        guard = 0;
        while ((m_since_load % TICK_DIV) != 5 && guard < 100) begin
            cyc(1);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            failures++;
            $display("FAIL phase_wait: got timeout want phase 5");
        end
        LED = 2'b10;
        cyc(1 + 8 + 128 + 3);

        // ALARM blink
        LED = 2'b11;
        cyc(1 + 16 + 4);

        // back to OFF
        LED = 2'b00;
        cyc(6);

        // HEAT then asynchronous reset pulse mid-cycle
        LED = 2'b01;
        cyc(12);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (LED_OUT !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: got %h want 0000", LED_OUT);
        end
        #1;
        rst = 1'b1;
        cyc(20);

        // randomized mode changes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) LED = 2'($urandom_range(0, 3));
            cyc(1);
        end

        // a few back-to-back changes, including changes on step edges
        for (int i = 0; i < 40; i++) begin
            LED = 2'($urandom_range(0, 3));
            cyc($urandom_range(1, 9));
        end

        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_driver_core.md
LED_DRIVER_CORE -- requirements
Module: led_driver

Interface
- REQ-001: Parameter TICK_DIV, default 8, means clock cycles per animation step; legal range 1..65535.
- REQ-002: Parameter PWM_DUTY, default 8, means PWM on-slots out of 16; legal range 0..16; used only with LED_DRIVER_PWM_EN.
- REQ-003: Port clk, input, 1 bit; the single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1 bit; asynchronous, active-low reset.
- REQ-005: Port LED, input, 2 bits; mode select: 00 OFF, 01 HEAT, 10 COOL, 11 ALARM.
- REQ-006: Port LED_OUT, output, 16 bits; LED bank drive, 1 = lit.

Function
- REQ-007: The block SHALL hold a registered mode (mode_q), a registered 16-bit pattern (pat_q) and a tick counter (tick_cnt, width clog2(TICK_DIV), minimum 1 bit).
- REQ-008: When LED != mode_q at a rising edge, the block SHALL set mode_q to LED, set tick_cnt to 0, and load pat_q with the new mode's initial pattern; this gives one cycle of latency from the input change to LED_OUT.
- REQ-009: The initial patterns SHALL be OFF 16'h0000, HEAT 16'h0001, COOL 16'h8000 and ALARM 16'hFFFF.
- REQ-010: When LED == mode_q, tick_cnt SHALL increment each cycle and wrap from TICK_DIV-1 to 0. A step SHALL occur on the edge where tick_cnt == TICK_DIV-1, so pat_q advances TICK_DIV cycles after a load. With TICK_DIV=1, a step SHALL occur every cycle.
- REQ-011: In OFF mode, pat_q SHALL stay at 16'h0000.
- REQ-012: In HEAT mode, each step SHALL rotate pat_q left by 1, so bit 15 wraps to bit 0.
- REQ-013: In COOL mode, each step SHALL rotate pat_q right by 1, so bit 0 wraps to bit 15.
- REQ-014: In ALARM mode, each step SHALL invert pat_q, toggling between 16'hFFFF and 16'h0000.
- REQ-015: A mode change SHALL take priority over a coincident step. The new initial pattern SHALL be loaded and no step SHALL be applied on that edge.
- REQ-016: Exactly one bit of LED_OUT SHALL be set in HEAT and COOL modes at all times, absent PWM gating.

Reset
- REQ-017: While rst=0, the block SHALL immediately clear mode_q to OFF, pat_q to 0, tick_cnt to 0 and the PWM counter to 0. LED_OUT SHALL be 16'h0000.
- REQ-018: An assertion of reset during animation SHALL abort it. After release, if LED != OFF, the first rising edge SHALL load that mode's initial pattern per REQ-008.

Configuration
- REQ-019: Without LED_DRIVER_PWM_EN defined, LED_OUT SHALL equal pat_q.
- REQ-020: With LED_DRIVER_PWM_EN defined:
  - a free-running 4-bit counter pwm_cnt SHALL increment every cycle, independent of mode changes;
  - LED_OUT SHALL equal pat_q AND {16{pwm_cnt < PWM_DUTY}};
  - PWM_DUTY=16 SHALL mean always on, and PWM_DUTY=0 SHALL mean always dark.

Structure
- REQ-021: Package led_driver_pkg SHALL hold the 2-bit mode type and its constants MODE_OFF, MODE_HEAT, MODE_COOL and MODE_ALARM. It SHALL also hold the four initial-pattern constants.
- REQ-022: The prescaler SHALL be a sub-module led_tick_gen with ports clk, rst, clear (input) and tick (output), parameterised by TICK_DIV.
- REQ-023: The top level SHALL hold the mode register, the pattern register and the optional PWM logic.

Verification
- REQ-024: Use TICK_DIV=8. Assert rst=0 for 10 cycles with LED=01, then release. Required: LED_OUT=0 during reset; 16'h0001 after 1 edge; 16'h0002 after 8 further edges.
- REQ-025: Hold HEAT for 128 cycles after the load. Required: LED_OUT returns to 16'h0001 (16 steps wrap); never zero and never more than one bit set.
- REQ-026: Switch LED from 01 to 10 mid-interval (tick_cnt=5). Required: next edge gives 16'h8000; 8 edges later 16'h4000; 16 steps later 16'h8000 again.
- REQ-027: Set LED=11. Required: 16'hFFFF next edge; 16'h0000 after 8 edges; 16'hFFFF after 16 edges.
- REQ-028: Set LED=00 from ALARM, then pulse rst=0 asynchronously mid-cycle during HEAT. Required: 16'h0000 the cycle after the 00 change; LED_OUT clears without waiting for a clock edge.
- REQ-029: Build with LED_DRIVER_PWM_EN and PWM_DUTY=4 in HEAT. Required: LED_OUT nonzero for exactly 4 of every 16 cycles. Build without the macro. Required: LED_OUT is continuously nonzero.
